// File: rtl/multinomial_feeder.sv
// Initiator for the multinomial sampler: buffers one softmax vector, streams it as a
// reload + add_en burst, then returns the sampled token over a valid/ready handshake.
module multinomial_feeder #(
    parameter int DW      = 40,
    parameter int N_CLASS = 98,
    parameter int TIMEOUT = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [6:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          chord_mode,
    output logic          busy,
    output logic          smp_reload,
    output logic          smp_add_en,
    output logic [DW-1:0] smp_din,
    output logic          smp_chord_flag,
    input  logic          smp_valid,
    input  logic [7:0]    smp_index,
    output logic          token_valid,
    input  logic          token_ready,
    output logic [7:0]    token,
    output logic          err,
    output logic [15:0]   draw_cnt
);

    // One counter serves both the stream position and the WAIT timeout.
    localparam int CW = $clog2((TIMEOUT > N_CLASS) ? TIMEOUT : N_CLASS);

    localparam logic [6:0]    ADDR_LIM  = 7'(N_CLASS);
    localparam logic [7:0]    INDEX_LIM = 8'(N_CLASS);
    localparam logic [CW-1:0] LAST_K    = CW'(N_CLASS - 1);
    localparam logic [CW-1:0] LAST_W    = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RELOAD = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem [N_CLASS];
    logic [6:0]      rd_addr;
    logic [CW-1:0]   cnt;

    // Buffer is writable only while idle so a vector cannot change under a burst.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && (wr_addr < ADDR_LIM)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Token handshake: token_valid stays high with token/err stable until token_ready
    // is seen high on a rising edge; that edge completes the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            smp_reload     <= 1'b0;
            smp_add_en     <= 1'b0;
            smp_din        <= '0;
            smp_chord_flag <= 1'b0;
            token_valid    <= 1'b0;
            token          <= 8'hFF;
            err            <= 1'b0;
            draw_cnt       <= '0;
            rd_addr        <= '0;
            cnt            <= '0;
        end else begin
            smp_reload <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= RELOAD;
                        busy           <= 1'b1;
                        smp_reload     <= 1'b1;
                        smp_chord_flag <= chord_mode;
                        rd_addr        <= '0;
                    end
                end
                RELOAD: begin
                    state      <= STREAM;
                    smp_add_en <= 1'b1;
                    smp_din    <= mem[rd_addr];
                    rd_addr    <= rd_addr + 7'd1;
                    cnt        <= '0;
                end
                STREAM: begin
                    if (cnt == LAST_K) begin
                        // Falling add_en is what triggers the sampler draw.
                        state      <= WAIT;
                        smp_add_en <= 1'b0;
                        smp_din    <= '0;
                        cnt        <= '0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        smp_din <= mem[rd_addr];
                        rd_addr <= rd_addr + 7'd1;
                    end
                end
                WAIT: begin
                    if (smp_valid) begin
                        state          <= HOLD;
                        token          <= smp_index;
                        err            <= (smp_index >= INDEX_LIM);
                        token_valid    <= 1'b1;
                        smp_chord_flag <= 1'b0;
                    end else if (cnt == LAST_W) begin
                        state          <= HOLD;
                        token          <= 8'hFF;
                        err            <= 1'b1;
                        token_valid    <= 1'b1;
                        smp_chord_flag <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (token_ready) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        token_valid <= 1'b0;
                        err         <= 1'b0;
                        draw_cnt    <= draw_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multinomial_feeder.sv
// Bench for multinomial_feeder: directed draw table, reset-mid-stream sequence, and
// randomized buffer loads/draws checked against a behavioural buffer + draw model.
module tb_multinomial_feeder;
    localparam int DW      = 40;
    localparam int N_CLASS = 98;
    localparam int TIMEOUT = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [6:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          chord_mode;
    logic          busy;
    logic          smp_reload;
    logic          smp_add_en;
    logic [DW-1:0] smp_din;
    logic          smp_chord_flag;
    logic          smp_valid;
    logic [7:0]    smp_index;
    logic          token_valid;
    logic          token_ready;
    logic [7:0]    token;
    logic          err;
    logic [15:0]   draw_cnt;

    always #5 clk = ~clk;

    multinomial_feeder #(.DW(DW), .N_CLASS(N_CLASS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .chord_mode(chord_mode), .busy(busy), .smp_reload(smp_reload),
        .smp_add_en(smp_add_en), .smp_din(smp_din), .smp_chord_flag(smp_chord_flag),
        .smp_valid(smp_valid), .smp_index(smp_index), .token_valid(token_valid),
        .token_ready(token_ready), .token(token), .err(err), .draw_cnt(draw_cnt)
    );

    // Reference model state
    logic [DW-1:0] ref_buf [N_CLASS];
    logic [15:0]   ref_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit         chord;
        int         resp_delay;   // WAIT cycle carrying smp_valid; -1 = never
        logic [7:0] idx;
        int         ready_delay;
        bit         disturb;
        logic [7:0] exp_tok;
        bit         exp_err;
    } vec_t;

    vec_t table_v [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_token(input int resp_delay, input logic [7:0] idx);
        return (resp_delay < 0) ? 8'hFF : idx;
    endfunction

    function automatic bit model_err(input int resp_delay, input logic [7:0] idx);
        return (resp_delay < 0) || (int'(idx) >= N_CLASS);
    endfunction

    // Called at a negedge while idle; returns at a negedge.
    task automatic write_word(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = 7'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (addr < N_CLASS) ref_buf[addr] = data;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_add_en"}, 64'(smp_add_en), 64'd0);
        check({tag, "_din"}, 64'(smp_din), 64'd0);
        check({tag, "_flag"}, 64'(smp_chord_flag), 64'd0);
        check({tag, "_tvalid"}, 64'(token_valid), 64'd0);
        check({tag, "_reload"}, 64'(smp_reload), 64'd0);
    endtask

    // Full draw from an idle negedge; start is driven immediately.
    task automatic do_draw(input bit chord, input int resp_delay, input logic [7:0] idx,
                           input int ready_delay, input bit disturb,
                           input logic [7:0] exp_tok, input bit exp_err);
        int w_hold;
        w_hold = (resp_delay < 0) ? TIMEOUT : resp_delay + 1;
        check("pre_start_busy", 64'(busy), 64'd0);
        start      = 1'b1;
        chord_mode = chord;
        @(negedge clk);
        start      = 1'b0;
        chord_mode = ~chord;
        check("reload_pulse", 64'(smp_reload), 64'd1);
        check("reload_busy", 64'(busy), 64'd1);
        check("reload_add_en", 64'(smp_add_en), 64'd0);
        check("reload_flag", 64'(smp_chord_flag), 64'(chord));
        for (int k = 0; k < N_CLASS; k++) begin
            @(negedge clk);
            check("stream_add_en", 64'(smp_add_en), 64'd1);
            check("stream_din", 64'(smp_din), 64'(ref_buf[k]));
            check("stream_flag", 64'(smp_chord_flag), 64'(chord));
            check("stream_reload", 64'(smp_reload), 64'd0);
            if (disturb && k == 10) begin
                wr_en     = 1'b1;
                wr_addr   = 7'd5;
                wr_data   = 40'hDEAD_BEEF_01;
                start     = 1'b1;
                smp_valid = 1'b1;
                smp_index = 8'd3;
            end else if (disturb && k == 11) begin
                wr_en     = 1'b0;
                start     = 1'b0;
                smp_valid = 1'b0;
                check("stream_ignore_valid", 64'(token_valid), 64'd0);
            end
        end
        for (int w = 0; w < w_hold; w++) begin
            @(negedge clk);
            check("wait_add_en", 64'(smp_add_en), 64'd0);
            check("wait_din", 64'(smp_din), 64'd0);
            check("wait_tvalid", 64'(token_valid), 64'd0);
            check("wait_flag", 64'(smp_chord_flag), 64'(chord));
            smp_valid = (w == resp_delay);
            smp_index = idx;
        end
        @(negedge clk);
        smp_valid = 1'b0;
        check("hold_tvalid", 64'(token_valid), 64'd1);
        check("hold_token", 64'(token), 64'(exp_tok));
        check("hold_err", 64'(err), 64'(exp_err));
        check("hold_flag", 64'(smp_chord_flag), 64'd0);
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_cnt", 64'(draw_cnt), 64'(ref_cnt));
        for (int i = 0; i < ready_delay; i++) begin
            smp_valid = 1'b1;
            smp_index = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("stall_tvalid", 64'(token_valid), 64'd1);
            check("stall_token", 64'(token), 64'(exp_tok));
            check("stall_err", 64'(err), 64'(exp_err));
            check("stall_cnt", 64'(draw_cnt), 64'(ref_cnt));
        end
        smp_valid   = 1'b0;
        token_ready = 1'b1;
        @(negedge clk);
        token_ready = 1'b0;
        ref_cnt     = ref_cnt + 16'd1;
        check("accept_tvalid", 64'(token_valid), 64'd0);
        check("accept_busy", 64'(busy), 64'd0);
        check("accept_cnt", 64'(draw_cnt), 64'(ref_cnt));
        check("accept_token_held", 64'(token), 64'(exp_tok));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        chord_mode = 1'b0; smp_valid = 1'b0; smp_index = '0; token_ready = 1'b0;
        ref_cnt = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        check("rst_token", 64'(token), 64'hFF);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cnt", 64'(draw_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < N_CLASS; k++) write_word(k, DW'(k + 1));

        // chord, resp_delay, idx, ready_delay, disturb, expected token, expected err
        table_v[0] = '{1'b0, 4,   8'd37,  0,  1'b0, 8'd37,  1'b0};
        table_v[1] = '{1'b1, 9,   8'd60,  20, 1'b0, 8'd60,  1'b0};
        table_v[2] = '{1'b0, -1,  8'd0,   0,  1'b0, 8'hFF,  1'b1};
        table_v[3] = '{1'b0, 2,   8'd120, 1,  1'b0, 8'd120, 1'b1};
        table_v[4] = '{1'b1, 0,   8'd97,  0,  1'b0, 8'd97,  1'b0};
        table_v[5] = '{1'b0, 1,   8'd98,  0,  1'b0, 8'd98,  1'b1};
        table_v[6] = '{1'b1, 511, 8'd7,   0,  1'b0, 8'd7,   1'b0};
        table_v[7] = '{1'b0, 3,   8'd0,   2,  1'b1, 8'd0,   1'b0};
        table_v[8] = '{1'b1, 5,   8'd255, 0,  1'b0, 8'hFF,  1'b1};

        for (int i = 0; i < 9; i++) begin
            if (i == 7) write_word(100, 40'hFF_FFFF_FFFF);
            do_draw(table_v[i].chord, table_v[i].resp_delay, table_v[i].idx,
                    table_v[i].ready_delay, table_v[i].disturb,
                    table_v[i].exp_tok, table_v[i].exp_err);
        end

        // Reset in the middle of a burst
        start = 1'b1; chord_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 40; k++) @(negedge clk);
        check("pre_rst_add_en", 64'(smp_add_en), 64'd1);
        check("pre_rst_din", 64'(smp_din), 64'(ref_buf[40]));
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        check("midrst_token", 64'(token), 64'hFF);
        check("midrst_cnt", 64'(draw_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_cnt = '0;
        @(negedge clk);
        do_draw(1'b0, 6, 8'd42, 0, 1'b0, 8'd42, 1'b0);

        // Randomized buffer loads and draws
        for (int it = 0; it < 16; it++) begin
            int n_wr, rd, rdy;
            logic [7:0] ix;
            bit ch;
            n_wr = $urandom_range(0, 6);
            for (int j = 0; j < n_wr; j++)
                write_word($urandom_range(0, 127), {8'($urandom), $urandom});
            rd  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 40);
            ix  = 8'($urandom_range(0, 255));
            rdy = $urandom_range(0, 5);
            ch  = 1'($urandom_range(0, 1));
            do_draw(ch, rd, ix, rdy, 1'($urandom_range(0, 1)),
                    model_token(rd, ix), model_err(rd, ix));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
